// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder with a carry register; init preloads the carry.
module serial_fa_bit (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic init_val,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    logic carry_r;
    logic prop_s;

    assign prop_s = a ^ b;
    assign sum    = prop_s ^ carry_r;
    // cout is the carry this bit hands to the next one, i.e. the register's next value
    assign cout   = (a & b) | (carry_r & prop_s);

    // Carry register: init wins over the normal ripple update
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 1'b0;
        end else if (init) begin
            carry_r <= init_val;
        end else begin
            carry_r <= cout;
        end
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// Sequences a WIDTH-bit add through a 1-bit core, LSB first, with valid/ready on both sides.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e             state_r;
    state_e             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   sum_sr_r;
    logic               carry_out_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               accept_s;
    logic               shift_s;
    logic               last_s;
    logic               fa_sum_s;
    logic               fa_cout_s;
    logic               init_val_s;
    logic [WIDTH-1:0]   b_load_s;

`ifdef SERIAL_ADD_SUB_EN
    // Subtract is a + ~b + 1: invert b on load and seed the carry with 1
    always_comb begin
        init_val_s = 1'b0;
        b_load_s   = b;
        if (sub) begin
            init_val_s = 1'b1;
            b_load_s   = ~b;
        end else begin
            init_val_s = 1'b0;
            b_load_s   = b;
        end
    end
`else
    assign init_val_s = 1'b0;
    assign b_load_s   = b;
`endif

    serial_fa_bit u_core (
        .clk      (clk),
        .rst      (rst),
        .init     (accept_s),
        .init_val (init_val_s),
        .a        (a_sr_r[0]),
        .b        (b_sr_r[0]),
        .sum      (fa_sum_s),
        .cout     (fa_cout_s)
    );

    // Next-state and per-cycle control decode
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        shift_s      = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                shift_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, handshake flags, shift registers and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cnt_r       <= '0;
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            sum_sr_r    <= '0;
            carry_out_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            if (accept_s) begin
                a_sr_r <= a;
                b_sr_r <= b_load_s;
                cnt_r  <= '0;
            end else if (shift_s) begin
                a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                sum_sr_r <= {fa_sum_s, sum_sr_r[WIDTH-1:1]};
                if (last_s) begin
                    cnt_r       <= '0;
                    carry_out_r <= fa_cout_s;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_sr_r;
    assign carry_out = carry_out_r;

endmodule
